// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared arbitration definitions.
//   arb_state_e : two-state packet-lock FSM encoding (ST_IDLE, ST_LOCKED).
//   rr_select   : round-robin pick over up to RR_MAX_REQ requesters. Requests
//                 at or above the pointer win first; if there are none, the
//                 lowest request overall wins (wrap).
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int RR_MAX_REQ = 8;
  localparam int RR_IDX_W   = 3;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_sel_t;

  // Callers zero-extend their request vector to RR_MAX_REQ bits.
  function automatic rr_sel_t rr_select(input logic [RR_MAX_REQ-1:0] valid,
                                        input logic [RR_IDX_W-1:0]   ptr);
    logic [RR_MAX_REQ-1:0] below;
    logic [RR_MAX_REQ-1:0] masked;
    logic [RR_MAX_REQ-1:0] pool;
    rr_sel_t               r;
    below  = (RR_MAX_REQ'(1) << ptr) - RR_MAX_REQ'(1);
    masked = valid & ~below;
    pool   = (masked != '0) ? masked : valid;
    r.found = (valid != '0);
    r.idx   = '0;
    // Descending scan: the last hit is the lowest set bit of the pool.
    for (int i = RR_MAX_REQ - 1; i >= 0; i--) begin
      if (pool[i]) r.idx = RR_IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bus bundle between the requesters/consumer and fifo_wr_arbiter.
// Handshake: a requester word transfers in a cycle where req_valid[i] and
// req_ready[i] are both high at the rising clock edge. req_ready is at most
// one-hot. On the read side a pop happens on the edge where ren is high and
// empty is low; rdata shows the head word whenever empty is low.
//   slave  : arbiter side (drives req_ready, rdata, status, dbg_state)
//   master : producer/consumer side
interface fifo_wr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  import fifo_wr_arbiter_pkg::*;

  localparam int W_ADDR = $clog2(DEPTH);
  localparam int W_ID   = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   flush;
  logic [WIDTH-1:0]       rdata;
  logic                   ren;
  logic                   empty;
  logic                   full;
  logic [W_ADDR:0]        level;
  logic [W_ID-1:0]        grant_id;
  logic                   locked;
  arb_state_e             dbg_state;

  modport slave (
    input  req_valid, req_last, req_data, flush, ren,
    output req_ready, rdata, empty, full, level, grant_id, locked, dbg_state
  );

  modport master (
    output req_valid, req_last, req_data, flush, ren,
    input  req_ready, rdata, empty, full, level, grant_id, locked, dbg_state
  );

endinterface

// File: rtl/fifo_wr_arbiter_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, rst_n (synchronous, active-low)
//   wen/wdata : push (ignored when full)
//   ren       : pop  (ignored when empty)
//   flush     : drop all contents; no push or pop takes effect that cycle
//   rdata     : head word, valid while !empty
//   empty, full, level (W_ADDR+1 bits)
module sync_fifo #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int W_ADDR = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              ren,
  input  logic              flush,
  output logic [WIDTH-1:0]  rdata,
  output logic              empty,
  output logic              full,
  output logic [W_ADDR:0]   level
);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [W_ADDR-1:0] r_wr_ptr;
  logic [W_ADDR-1:0] r_rd_ptr;
  logic [W_ADDR:0]   r_count;
  logic              w_do_wr;
  logic              w_do_rd;

  assign w_do_wr = wen & ~full & ~flush;
  assign w_do_rd = ren & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + W_ADDR'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + W_ADDR'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (W_ADDR+1)'(1);
        2'b01:   r_count <= r_count - (W_ADDR+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; rdata is meaningless until the first write.
  always_ff @(posedge clk) begin
    if (rst_n && w_do_wr) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == (W_ADDR+1)'(DEPTH));
  assign level = r_count;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the write port of one sync_fifo between N_REQ
// requesters with round-robin arbitration and packet locking, so a
// multi-word packet (ended by req_last) lands in the FIFO contiguously.
// The read side passes straight through to one consumer.
//   clk, rst (synchronous, active-high)
//   bus.req_valid/req_last/req_data -> requester words
//   bus.req_ready                   <- at most one-hot, combinational
//   bus.flush                       -> drop FIFO contents, abort any lock
//   bus.rdata/ren/empty/full/level  -> FIFO read side and status
//   bus.grant_id, bus.locked        <- lock owner / last granted, lock flag
//   bus.dbg_state                   <- FSM state
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int W_ADDR = $clog2(DEPTH)
) (
  input logic             clk,
  input logic             rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int W_ID = $clog2(N_REQ);

  arb_state_e            r_state;
  logic [W_ID-1:0]       r_owner;
  logic [W_ID-1:0]       r_rr_ptr;
  logic [W_ID-1:0]       r_grant;

  rr_sel_t               w_rr;
  logic [W_ID-1:0]       w_sel;
  logic [N_REQ-1:0]      w_ready;
  logic [W_ID-1:0]       w_xfer_id;
  logic                  w_wen;
  logic                  w_last;
  logic [WIDTH-1:0]      w_wdata;
  logic                  w_ren;
  logic                  w_empty;
  logic                  w_full;
  logic [W_ADDR:0]       w_level;
  logic [WIDTH-1:0]      w_rdata;
  logic [W_ID-1:0]       w_ptr_next;

  // Ready never looks at ren: a word is refused when full even if the
  // consumer pops in the same cycle, keeping ready off the read path.
  always_comb begin
    w_rr    = rr_select(RR_MAX_REQ'(bus.req_valid), RR_IDX_W'(r_rr_ptr));
    w_sel   = w_rr.idx[W_ID-1:0];
    w_ready = '0;
    if (!rst && !w_full && !bus.flush) begin
      // While locked the owner is offered ready even with its valid low,
      // so everyone else stays held off until the packet ends.
      if (r_state == ST_LOCKED) w_ready[r_owner] = 1'b1;
      else if (w_rr.found)      w_ready[w_sel]   = 1'b1;
    end
  end

  assign w_xfer_id = (r_state == ST_LOCKED) ? r_owner : w_sel;
  assign w_wen     = |(w_ready & bus.req_valid);
  assign w_last    = bus.req_last[w_xfer_id];

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (W_ID'(i) == w_xfer_id) w_wdata = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_ren      = bus.ren & ~w_empty;
  assign w_ptr_next = (w_xfer_id == W_ID'(N_REQ - 1)) ? '0 : w_xfer_id + W_ID'(1);

  // rr_ptr only moves when a packet completes; an aborted (flushed) packet
  // leaves it where it was.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_grant  <= '0;
    end else if (bus.flush) begin
      r_state  <= ST_IDLE;
    end else if (w_wen) begin
      r_grant <= w_xfer_id;
      case (r_state)
        ST_IDLE: begin
          if (w_last) begin
            r_rr_ptr <= w_ptr_next;
          end else begin
            r_state <= ST_LOCKED;
            r_owner <= w_xfer_id;
          end
        end
        ST_LOCKED: begin
          if (w_last) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= w_ptr_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .W_ADDR(W_ADDR)
  ) u_fifo (
    .clk  (clk),
    .rst_n(~rst),
    .wen  (w_wen),
    .wdata(w_wdata),
    .ren  (w_ren),
    .flush(bus.flush),
    .rdata(w_rdata),
    .empty(w_empty),
    .full (w_full),
    .level(w_level)
  );

  assign bus.req_ready = w_ready;
  assign bus.rdata     = w_rdata;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.level     = w_level;
  // r_grant equals r_owner while locked, and the last transfer otherwise.
  assign bus.grant_id  = r_grant;
  assign bus.locked    = (r_state == ST_LOCKED);
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  fifo_wr_arbiter_if #(.N_REQ(N), .WIDTH(W), .DEPTH(DEPTH)) bus ();

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check / scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];

  bit         mon_en   = 1'b0;
  bit         m_locked;
  int         m_owner;
  int         m_ptr;
  int         m_grant;
  int         m_level;
  logic [N-1:0] last_xfer = '0;
  int         n_words = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_grant  = 0;
    m_level  = 0;
    exp_q.delete();
  endtask

  // Reference model of the arbiter, evaluated mid-cycle on the stable
  // inputs; state advances as the DUT will at the following rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [N-1:0] exp_rdy;
      logic [N-1:0] xfer;
      int           id;
      exp_rdy = '0;
      if (!rst && !bus.flush && m_level < DEPTH) begin
        if (m_locked) exp_rdy[m_owner] = 1'b1;
        else begin
          for (int k = 0; k < N; k++) begin
            if (exp_rdy == '0 && bus.req_valid[(m_ptr + k) % N])
              exp_rdy[(m_ptr + k) % N] = 1'b1;
          end
        end
      end
      check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      check("level",     64'(bus.level),     64'(m_level));
      check("empty",     64'(bus.empty),     64'(m_level == 0));
      check("full",      64'(bus.full),      64'(m_level == DEPTH));
      check("locked",    64'(bus.locked),    64'(m_locked));
      check("dbg_state", 64'(bus.dbg_state == ST_LOCKED), 64'(m_locked));
      check("grant_id",  64'(bus.grant_id),  64'(m_grant));
      xfer = '0;
      if (rst) begin
        model_reset();
      end else begin
        if (bus.ren && m_level > 0) begin
          check("rdata", 64'(bus.rdata), 64'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        xfer = exp_rdy & bus.req_valid;
        if (bus.flush) begin
          exp_q.delete();
          m_locked = 1'b0;
        end else if (xfer != '0) begin
          id = 0;
          for (int i = 0; i < N; i++) if (xfer[i]) id = i;
          exp_q.push_back(bus.req_data[id*W +: W]);
          n_words++;
          m_grant = id;
          if (bus.req_last[id]) begin
            m_locked = 1'b0;
            m_ptr    = (id + 1) % N;
          end else begin
            m_locked = 1'b1;
            m_owner  = id;
          end
        end
        m_level = exp_q.size();
      end
      last_xfer = xfer;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [W-1:0] d);
    bus.req_valid[i]        = v;
    bus.req_last[i]         = l;
    bus.req_data[i*W +: W]  = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, '0);
  endtask

  task automatic drain(input int cycles);
    idle_all();
    bus.ren = 1'b1;
    repeat (cycles) tick();
    bus.ren = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] sv;
    logic [N-1:0] sl;
    int           seq [N];
    int           soak_start;
    int           cyc;

    rst = 1'b1;
    bus.flush = 1'b0;
    bus.ren   = 1'b0;
    idle_all();
    model_reset();
    repeat (2) tick();
    mon_en = 1'b1;
    set_req(0, 1'b1, 1'b1, 32'hDEAD_0000);
    @(negedge clk);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_level", 64'(bus.level), 64'd0);
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_full",  64'(bus.full),  64'd0);
    check("rst_grant", 64'(bus.grant_id), 64'd0);
    check("rst_lock",  64'(bus.locked), 64'd0);
    tick();
    rst = 1'b0;
    idle_all();

    // Round robin: everyone valid with single-word packets.
    bus.ren = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, {8'(i), 24'(k)});
      @(negedge clk);
      check("rr_grant", 64'(bus.req_ready), 64'(4'b0001 << (k % N)));
      tick();
    end
    drain(3);
    @(negedge clk);
    check("rr_drained", 64'(bus.level), 64'd0);
    tick();

    // Packet lock: req1 3-word packet, req2 always valid.
    bus.ren = 1'b1;
    set_req(1, 1'b1, 1'b0, 32'h1111_0001);
    set_req(2, 1'b1, 1'b1, 32'h2222_0001);
    @(negedge clk); check("lock_w1", 64'(bus.req_ready), 64'b0010);
    tick();
    set_req(1, 1'b0, 1'b0, 32'h1111_00FF);
    @(negedge clk); check("lock_gap", 64'(bus.req_ready), 64'b0010);
    check("lock_flag", 64'(bus.locked), 64'd1);
    tick();
    set_req(1, 1'b1, 1'b0, 32'h1111_0002);
    @(negedge clk); check("lock_w2", 64'(bus.req_ready), 64'b0010);
    tick();
    set_req(1, 1'b1, 1'b1, 32'h1111_0003);
    @(negedge clk); check("lock_w3", 64'(bus.req_ready), 64'b0010);
    tick();
    set_req(1, 1'b0, 1'b0, '0);
    @(negedge clk); check("lock_next", 64'(bus.req_ready), 64'b0100);
    tick();
    drain(3);

    // Full backpressure: ren low, five single words from req0.
    for (int k = 0; k < 5; k++) begin
      set_req(0, 1'b1, 1'b1, {8'hF0, 24'(k)});
      @(negedge clk);
      if (k < 4) check("full_acc", 64'(bus.req_ready), 64'b0001);
      else begin
        check("full_rdy",   64'(bus.req_ready), 64'd0);
        check("full_flag",  64'(bus.full), 64'd1);
        check("full_level", 64'(bus.level), 64'd4);
      end
      tick();
    end
    bus.ren = 1'b1;
    @(negedge clk); check("full_pop_refuse", 64'(bus.req_ready), 64'd0);
    tick();
    bus.ren = 1'b0;
    @(negedge clk); check("full_retry", 64'(bus.req_ready), 64'b0001);
    check("full_retry_lvl", 64'(bus.level), 64'd3);
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    @(negedge clk); check("full_again", 64'(bus.level), 64'd4);
    tick();
    drain(6);

    // Flush mid-packet: req0 locked after two words, rr_ptr is 1.
    set_req(0, 1'b1, 1'b0, 32'hA0A0_0001);
    @(negedge clk); check("flush_w1", 64'(bus.req_ready), 64'b0001);
    tick();
    set_req(0, 1'b1, 1'b0, 32'hA0A0_0002);
    tick();
    bus.flush = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'hA0A0_0003);
    set_req(3, 1'b1, 1'b1, 32'h3333_0001);
    @(negedge clk); check("flush_rdy", 64'(bus.req_ready), 64'd0);
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_level", 64'(bus.level), 64'd0);
    check("flush_empty", 64'(bus.empty), 64'd1);
    check("flush_lock",  64'(bus.locked), 64'd0);
    check("flush_next",  64'(bus.req_ready), 64'b1000);
    tick();
    drain(4);

    // Reset mid-packet: move rr_ptr to 3, then lock req1 with level 3.
    set_req(2, 1'b1, 1'b1, 32'h2222_0010);
    tick();
    drain(3);
    for (int k = 0; k < 3; k++) begin
      set_req(1, 1'b1, 1'b0, {8'h11, 24'(k + 16)});
      @(negedge clk); check("rstp_word", 64'(bus.req_ready), 64'b0010);
      tick();
    end
    rst = 1'b1;
    set_req(0, 1'b1, 1'b1, 32'h0000_0020);
    set_req(3, 1'b1, 1'b1, 32'h3333_0020);
    @(negedge clk); check("rstp_pre_lvl", 64'(bus.level), 64'd3);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstp_level", 64'(bus.level), 64'd0);
    check("rstp_lock",  64'(bus.locked), 64'd0);
    check("rstp_grant", 64'(bus.grant_id), 64'd0);
    check("rstp_prio",  64'(bus.req_ready), 64'b0001);
    tick();
    drain(6);

    // Random soak: hold each word until it is accepted.
    sv = '0;
    sl = '0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    soak_start = n_words;
    cyc = 0;
    while ((n_words - soak_start) < 1000 && cyc < 20000) begin
      for (int i = 0; i < N; i++) begin
        if (last_xfer[i]) seq[i]++;
        if (last_xfer[i] || !sv[i]) begin
          sv[i] = ($urandom_range(0, 3) != 0);
          sl[i] = ($urandom_range(0, 2) == 0);
        end
        set_req(i, sv[i], sl[i], {8'(i), 24'(seq[i])});
      end
      bus.ren = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    check("soak_words", 64'((n_words - soak_start) >= 1000), 64'd1);
    drain(DEPTH + 4);
    @(negedge clk);
    check("soak_empty", 64'(bus.empty), 64'd1);
    check("soak_q",     64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
